// File: rtl/conv_frame_ctrl_if.sv
// Pixel-side handshake and window-side result bundle for conv_frame_ctrl.
// Ports carried:
//   i_start, i_abort, i_valid : frame control and pixel strobe (into the controller)
//   o_ready, o_lb_we          : accept qualifier and line-buffer write strobe
//   o_col, o_row              : coordinates of the pixel being accepted
//   o_valid, o_out_col/row    : registered window-available flag and top-left corner
//   o_first, o_last           : registered first/last window qualifiers
//   o_busy, o_done            : frame in progress / one-cycle frame-complete pulse
// The master modport is the pixel source; the slave modport is the controller.
interface conv_frame_ctrl_if #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic          i_start;
    logic          i_abort;
    logic          i_valid;
    logic          o_ready;
    logic          o_lb_we;
    logic [CW-1:0] o_col;
    logic [RW-1:0] o_row;
    logic          o_valid;
    logic [CW-1:0] o_out_col;
    logic [RW-1:0] o_out_row;
    logic          o_first;
    logic          o_last;
    logic          o_busy;
    logic          o_done;

    modport master (
        output i_start, i_abort, i_valid,
        input  o_ready, o_lb_we, o_col, o_row, o_valid, o_out_col, o_out_row,
        input  o_first, o_last, o_busy, o_done
    );

    modport slave (
        input  i_start, i_abort, i_valid,
        output o_ready, o_lb_we, o_col, o_row, o_valid, o_out_col, o_out_row,
        output o_first, o_last, o_busy, o_done
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolution datapath.
// Accepts one pixel per cycle in raster order over an IMG_W x IMG_H frame,
// tracks the (row, col) of each accepted pixel, drives the line-buffer write
// strobe, and flags (one cycle later) every accept that completes a K x K window.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : conv_frame_ctrl_if slave modport (see interface header)
module conv_frame_ctrl #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    conv_frame_ctrl_if.slave   bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(K - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] col_r;
    logic [CW-1:0] col_s;
    logic [RW-1:0] row_r;
    logic [RW-1:0] row_s;

    logic          accept_s;
    logic          win_s;
    logic          last_pix_s;
    logic [CW-1:0] win_col_s;
    logic [RW-1:0] win_row_s;

    logic          valid_r;
    logic          first_r;
    logic          last_r;
    logic [CW-1:0] out_col_r;
    logic [RW-1:0] out_row_r;

    // Abort suppresses the pixel offered in the same cycle.
    assign accept_s = bus.i_valid & (state_r == ST_RUN) & ~bus.i_abort;

    // Window test on the pixel being accepted; the subtraction is only consumed
    // when the window test passes, so it never wraps.
    always_comb begin
        win_s      = 1'b0;
        last_pix_s = 1'b0;
        win_col_s  = col_r - COL_WIN;
        win_row_s  = row_r - ROW_WIN;
        if (accept_s && (row_r >= ROW_WIN) && (col_r >= COL_WIN)) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        if ((row_r == ROW_MAX) && (col_r == COL_MAX)) begin
            last_pix_s = 1'b1;
        end else begin
            last_pix_s = 1'b0;
        end
    end

    // Next-state and raster counter logic; abort outranks everything but reset.
    always_comb begin
        state_s = state_r;
        col_s   = col_r;
        row_s   = row_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_abort) begin
                    col_s = COL_ZERO;
                    row_s = ROW_ZERO;
                end else if (bus.i_start) begin
                    state_s = ST_RUN;
                    col_s   = COL_ZERO;
                    row_s   = ROW_ZERO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.i_abort) begin
                    state_s = ST_IDLE;
                    col_s   = COL_ZERO;
                    row_s   = ROW_ZERO;
                end else if (accept_s) begin
                    if (col_r == COL_MAX) begin
                        col_s = COL_ZERO;
                        if (row_r == ROW_MAX) begin
                            row_s   = ROW_ZERO;
                            state_s = ST_DONE;
                        end else begin
                            row_s = row_r + ROW_ONE;
                        end
                    end else begin
                        col_s = col_r + COL_ONE;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                // Done lasts exactly one cycle whether or not abort is present.
                state_s = ST_IDLE;
                col_s   = COL_ZERO;
                row_s   = ROW_ZERO;
            end
            default: begin
                state_s = ST_IDLE;
                col_s   = COL_ZERO;
                row_s   = ROW_ZERO;
            end
        endcase
    end

    // State and raster counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            col_r   <= COL_ZERO;
            row_r   <= ROW_ZERO;
        end else begin
            state_r <= state_s;
            col_r   <= col_s;
            row_r   <= row_s;
        end
    end

    // Window result registers; coordinates hold across non-window cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r   <= 1'b0;
            first_r   <= 1'b0;
            last_r    <= 1'b0;
            out_col_r <= COL_ZERO;
            out_row_r <= ROW_ZERO;
        end else begin
            valid_r <= win_s;
            first_r <= win_s & (win_row_s == ROW_ZERO) & (win_col_s == COL_ZERO);
            last_r  <= win_s & last_pix_s;
            if (win_s) begin
                out_col_r <= win_col_s;
                out_row_r <= win_row_s;
            end else begin
                out_col_r <= out_col_r;
                out_row_r <= out_row_r;
            end
        end
    end

    assign bus.o_ready   = (state_r == ST_RUN);
    assign bus.o_lb_we   = accept_s;
    assign bus.o_col     = col_r;
    assign bus.o_row     = row_r;
    assign bus.o_valid   = valid_r;
    assign bus.o_first   = first_r;
    assign bus.o_last    = last_r;
    assign bus.o_out_col = out_col_r;
    assign bus.o_out_row = out_row_r;
    assign bus.o_busy    = (state_r != ST_IDLE);
    assign bus.o_done    = (state_r == ST_DONE);
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench for conv_frame_ctrl: two instances (32x32/K=5 and 8x6/K=3)
// share one stimulus stream. A frame-level reference model (accept index n,
// pixel = (n / W, n % W)) predicts every cycle's outputs and every window,
// pushing them into queues that a negedge monitor pops and compares.
module tb_conv_frame_ctrl;
    logic clk;
    logic rst_n;

    conv_frame_ctrl_if #(.IMG_W(32), .IMG_H(32)) bus_a ();
    conv_frame_ctrl_if #(.IMG_W(8),  .IMG_H(6))  bus_b ();

    conv_frame_ctrl #(.IMG_W(32), .IMG_H(32), .K(5)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_a)
    );

    conv_frame_ctrl #(.IMG_W(8), .IMG_H(6), .K(3)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        lb_we;
        logic [15:0] col;
        logic [15:0] row;
        logic        busy;
        logic        done;
        logic        valid;
        logic        first;
        logic        last;
    } cyc_t;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] c;
    } win_t;

    cyc_t cq0[$];
    cyc_t cq1[$];
    win_t wq0[$];
    win_t wq1[$];

    // Reference model state (frame view: mode 0 idle, 1 running, 2 done)
    int m_mode [2];
    int m_n    [2];
    bit m_pv   [2];
    bit m_pf   [2];
    bit m_pl   [2];

    int errors;
    int checks;
    bit end_req;
    int fcnt [2];

    function automatic int pw(input int d);
        return (d == 0) ? 32 : 8;
    endfunction
    function automatic int ph(input int d);
        return (d == 0) ? 32 : 6;
    endfunction
    function automatic int pk(input int d);
        return (d == 0) ? 5 : 3;
    endfunction
    function automatic int nwin(input int d);
        return (pw(d) - pk(d) + 1) * (ph(d) - pk(d) + 1);
    endfunction

    task automatic model(input int d, input bit st, input bit ab, input bit va, input bit rs,
                         output cyc_t e, output bit wv, output win_t w);
        int r;
        int c;
        e  = '0;
        wv = 1'b0;
        w  = '0;
        if (rs) begin
            m_mode[d] = 0; m_n[d] = 0;
            m_pv[d] = 1'b0; m_pf[d] = 1'b0; m_pl[d] = 1'b0;
        end else begin
            r = m_n[d] / pw(d);
            c = m_n[d] % pw(d);
            e.ready = (m_mode[d] == 1);
            e.lb_we = e.ready && va && !ab;
            e.col   = 16'(c);
            e.row   = 16'(r);
            e.busy  = (m_mode[d] != 0);
            e.done  = (m_mode[d] == 2);
            e.valid = m_pv[d];
            e.first = m_pf[d];
            e.last  = m_pl[d];
            m_pv[d] = 1'b0; m_pf[d] = 1'b0; m_pl[d] = 1'b0;
            if (e.lb_we && r >= pk(d) - 1 && c >= pk(d) - 1) begin
                wv = 1'b1;
                w.r = 16'(r - pk(d) + 1);
                w.c = 16'(c - pk(d) + 1);
                m_pv[d] = 1'b1;
                m_pf[d] = (w.r == 16'd0) && (w.c == 16'd0);
                m_pl[d] = (r == ph(d) - 1) && (c == pw(d) - 1);
            end
            if (ab) begin
                m_mode[d] = 0; m_n[d] = 0;
            end else if (m_mode[d] == 0 && st) begin
                m_mode[d] = 1; m_n[d] = 0;
            end else if (m_mode[d] == 1 && e.lb_we) begin
                m_n[d] = m_n[d] + 1;
                if (m_n[d] == pw(d) * ph(d)) begin
                    m_mode[d] = 2; m_n[d] = 0;
                end
            end else if (m_mode[d] == 2) begin
                m_mode[d] = 0;
            end
        end
    endtask

    task automatic step(input bit st, input bit ab, input bit va, input bit rs);
        cyc_t e;
        bit   wv;
        win_t w;
        @(posedge clk);
        #1;
        rst_n = !rs;
        bus_a.i_start = st; bus_a.i_abort = ab; bus_a.i_valid = va;
        bus_b.i_start = st; bus_b.i_abort = ab; bus_b.i_valid = va;
        for (int d = 0; d < 2; d++) begin
            // An async reset wipes the window that would have shown this cycle.
            if (rs && m_pv[d]) begin
                if (d == 0) void'(wq0.pop_back());
                else        void'(wq1.pop_back());
            end
            model(d, st, ab, va, rs, e, wv, w);
            if (d == 0) begin
                cq0.push_back(e);
                if (wv) wq0.push_back(w);
            end else begin
                cq1.push_back(e);
                if (wv) wq1.push_back(w);
            end
        end
    endtask

    task automatic chk(input string nm, input int d, input int act, input int exp_v);
        checks = checks + 1;
        if (act != exp_v) begin
            errors = errors + 1;
            $display("FAIL %s dut%0d @%0t: got %0d expected %0d", nm, d, $time, act, exp_v);
        end
    endtask

    task automatic cmp_cyc(input int d, input cyc_t a, input cyc_t e);
        chk("ready", d, int'(a.ready), int'(e.ready));
        chk("lb_we", d, int'(a.lb_we), int'(e.lb_we));
        chk("col",   d, int'(a.col),   int'(e.col));
        chk("row",   d, int'(a.row),   int'(e.row));
        chk("busy",  d, int'(a.busy),  int'(e.busy));
        chk("done",  d, int'(a.done),  int'(e.done));
        chk("valid", d, int'(a.valid), int'(e.valid));
        chk("first", d, int'(a.first), int'(e.first));
        chk("last",  d, int'(a.last),  int'(e.last));
    endtask

    task automatic cmp_win(input int d, input logic [15:0] orow, input logic [15:0] ocol);
        win_t w;
        if ((d == 0 && wq0.size() == 0) || (d == 1 && wq1.size() == 0)) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL win_q dut%0d @%0t: got o_valid expected no window", d, $time);
        end else begin
            if (d == 0) w = wq0.pop_front();
            else        w = wq1.pop_front();
            chk("out_row", d, int'(orow), int'(w.r));
            chk("out_col", d, int'(ocol), int'(w.c));
        end
    endtask

    task automatic frame_count(input int d, input cyc_t a);
        if (!a.busy) begin
            fcnt[d] = 0;
        end else begin
            if (a.valid) fcnt[d] = fcnt[d] + 1;
            if (a.done) chk("frame_windows", d, fcnt[d], nwin(d));
        end
    endtask

    cyc_t act_a, act_b, exp_a, exp_b;

    // Monitor: sample mid-cycle, pop per-cycle expectations and windows.
    always @(negedge clk) begin
        act_a.ready = bus_a.o_ready;  act_a.lb_we = bus_a.o_lb_we;
        act_a.col   = 16'(bus_a.o_col); act_a.row = 16'(bus_a.o_row);
        act_a.busy  = bus_a.o_busy;   act_a.done  = bus_a.o_done;
        act_a.valid = bus_a.o_valid;  act_a.first = bus_a.o_first;
        act_a.last  = bus_a.o_last;
        act_b.ready = bus_b.o_ready;  act_b.lb_we = bus_b.o_lb_we;
        act_b.col   = 16'(bus_b.o_col); act_b.row = 16'(bus_b.o_row);
        act_b.busy  = bus_b.o_busy;   act_b.done  = bus_b.o_done;
        act_b.valid = bus_b.o_valid;  act_b.first = bus_b.o_first;
        act_b.last  = bus_b.o_last;
        if (cq0.size() != 0) begin
            exp_a = cq0.pop_front();
            cmp_cyc(0, act_a, exp_a);
            if (act_a.valid) cmp_win(0, 16'(bus_a.o_out_row), 16'(bus_a.o_out_col));
            frame_count(0, act_a);
        end
        if (cq1.size() != 0) begin
            exp_b = cq1.pop_front();
            cmp_cyc(1, act_b, exp_b);
            if (act_b.valid) cmp_win(1, 16'(bus_b.o_out_row), 16'(bus_b.o_out_col));
            frame_count(1, act_b);
        end
        if (end_req) begin
            chk("win_q_left", 0, wq0.size(), 0);
            chk("win_q_left", 1, wq1.size(), 0);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    // Stimulus driver.
    initial begin
        errors = 0; checks = 0; end_req = 1'b0;
        fcnt[0] = 0; fcnt[1] = 0;
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_n[d] = 0; m_pv[d] = 1'b0; m_pf[d] = 1'b0; m_pl[d] = 1'b0;
        end
        rst_n = 1'b0;
        bus_a.i_start = 1'b0; bus_a.i_abort = 1'b0; bus_a.i_valid = 1'b0;
        bus_b.i_start = 1'b0; bus_b.i_abort = 1'b0; bus_b.i_valid = 1'b0;

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        // Valid pulses while idle are ignored; start together with abort does not start.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'(i % 2), 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Continuous frame.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (1030) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Gapped frame at about 50% valid.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 6000 && m_mode[0] != 0; g++)
            step(1'b0, 1'b0, 1'($urandom % 2), 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Start during RUN at row 10 is ignored.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 2000 && m_n[0] != 320; g++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int g = 0; g < 2000 && m_mode[0] != 0; g++) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Abort with a pixel offered at (10,7), then a full restart.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 2000 && m_n[0] != 327; g++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 2000 && m_mode[0] != 0; g++) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Async reset between edges at (20,3).
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 2000 && m_n[0] != 643; g++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Random control mix: sparse start/abort, 75% valid.
        for (int i = 0; i < 3000; i++)
            step(1'($urandom % 64 == 0), 1'($urandom % 256 == 0), 1'($urandom % 4 != 0), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        end_req = 1'b1;
        repeat (3) @(posedge clk);
    end
endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame sequencer for the convolution datapath. It accepts one pixel per cycle in raster order over an IMG_W x IMG_H frame and tracks the row and column of each pixel. It drives the line-buffer write strobe and coordinates, and flags every cycle on which a complete K x K window is available, giving (IMG_W-K+1) x (IMG_H-K+1) valid outputs per frame (784 for the 32x32 / K=5 default). It also brackets each frame with start, abort and done control.

## Interface
- IMG_W, 32, frame width in pixels (>= K)
- IMG_H, 32, frame height in pixels (>= K)
- K, 5, square kernel size (>= 2)
- CW / RW: localparams, $clog2(IMG_W) / $clog2(IMG_H), minimum 1

- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start a frame; honoured only in IDLE
- i_abort  in  1  synchronous frame abort; highest priority after reset
- i_valid  in  1  input pixel present this cycle
- o_ready  out  1  controller accepts pixels; combinational, equals (state==RUN)
- o_lb_we  out  1  line-buffer write; combinational, i_valid & o_ready & ~i_abort
- o_col  out  CW  column of the pixel being accepted (current counter value)
- o_row  out  RW  row of the pixel being accepted
- o_valid  out  1  registered; a full window completed on the previous accept
- o_out_col  out  CW  registered window top-left column
- o_out_row  out  RW  registered window top-left row
- o_first  out  1  registered; qualifies the first window of the frame (0,0)
- o_last  out  1  registered; qualifies the last window (IMG_W-K, IMG_H-K)
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse, state==DONE

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: o_ready=0. i_start with i_abort low clears the counters and moves to RUN. i_valid is ignored in IDLE.
- RUN: an accept is o_lb_we=1.
  - Each accept increments col.
  - When col==IMG_W-1, col wraps to 0 and row increments.
  - An accept at (IMG_H-1, IMG_W-1) moves to DONE, with counters cleared.
- DONE: held for one cycle, then moves to IDLE. i_start is ignored in DONE.
- i_start is ignored in RUN and DONE.
- i_abort in RUN or DONE:
  - The next state is IDLE and the counters are cleared.
  - No o_done is produced.
  - The pixel presented in the same cycle is not accepted.
- Window test on accept at (r,c): a window is available when r >= K-1 and c >= K-1. In that case:
  - o_valid is set for the next cycle.
  - o_out_row = r-(K-1) and o_out_col = c-(K-1).
  - o_first is set when both are 0.
  - o_last is set when the accept is at (IMG_H-1, IMG_W-1).
- A cycle with no accept (including i_valid gaps in RUN) clears o_valid, o_first and o_last on the next edge. o_out_row and o_out_col hold their values.
- Subtraction is done at full counter width. It is used only under the window test, so it never underflows.

## Timing
- Reset values: state=IDLE, row=col=0, and o_valid, o_first, o_last, o_out_row, o_out_col, o_done, o_busy all 0. o_ready and o_lb_we are therefore 0.
- Reset mid-frame takes effect immediately and asynchronously. There is no o_done afterwards.
- Window latency is 1 cycle from the accepting edge to o_valid.
- The last accept puts the FSM in DONE. o_done, o_valid and o_last are all high in the same following cycle.
- The earliest restart is i_start in the cycle after DONE. The first accept of the new frame comes 1 cycle after i_start.
- Throughput is 1 pixel per cycle. A frame with no gaps takes IMG_W*IMG_H accepts, plus 1 start cycle and 1 done cycle.

## Test plan
- **Continuous frame (defaults).** Reset, i_start, then i_valid=1 for 1024 cycles.
  - Exactly 784 o_valid.
  - The first o_valid follows accept #133 (r4,c4), with o_first and out (0,0).
  - o_last has out (27,27) and coincides with o_done.
  - o_busy falls after DONE.
- **Gapped input.** i_valid random at 50%.
  - The o_valid count is still 784.
  - The (o_out_row, o_out_col) sequence is identical to the continuous case.
  - No o_valid in the cycle after a gap.
- **Ignored controls.**
  - i_valid pulses in IDLE: o_ready=0, o_lb_we=0, counters stay 0.
  - i_start at row 10 during RUN: no effect, and the frame completes normally.
- **Abort.** Assert i_abort together with i_valid at (r10,c7).
  - o_lb_we=0 that cycle.
  - IDLE next cycle.
  - No o_done.
  - A new i_start restarts at (0,0) and yields 784 windows.
- **Async reset mid-frame.** Drop i_rst_n at (r20,c3) away from a clock edge.
  - All outputs are 0 before the next edge.
  - After release: IDLE and o_ready=0.
- **Parameter sweep.** IMG_W=8, IMG_H=6, K=3.
  - 48 accepts and 24 o_valid.
  - The last window is (3,5).
  - o_done follows accept (5,7) by 1 cycle.
